regfile_param: RTL and testbench

Parametrised multi-port register file with one write port and two independent combinational read ports. Adds the following features:
- configurable width and depth;
- optional write-to-read bypass;
- a write-acknowledge pulse;
- a sequential clear engine that zeroes every register, one per cycle, under a busy/done handshake.

It is the datapath register storage for the lab datapath. Its read ports feed the ALU operand paths and HEX display logic.

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_clear_fsm.sv | 70 +++++++
 rtl/regfile_param.sv | 115 +++++++++++
 tb/tb_regfile_param.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the datapath register file.
package regfile_pkg;

  // Clear-engine states.
  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_DONE
  } state_t;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned NREGS_DEF  = 4;

endpackage

// File: rtl/regfile_clear_fsm.sv
// Sequential clear engine: walks an index over every register, issuing one
// zeroing write per cycle, with a busy/done handshake decoded from state.
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int unsigned NREGS  = NREGS_DEF,
  parameter int unsigned ADDR_W = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_done,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;

  // State and clear-index registers; reset aborts any clear in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic and the zeroing write strobe.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    clr_we   = 1'b0;
    clr_addr = idx_q;
    unique case (state_q)
      S_IDLE: begin
        if (clr_req) begin
          state_d = S_CLEAR;
          idx_d   = '0;
        end
      end
      S_CLEAR: begin
        clr_we = 1'b1;
        // Stop on the last register so the index never wraps.
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + ADDR_W'(1);
        end
      end
      S_DONE: begin
        // clr_req is ignored here; always return to idle.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Handshake outputs come straight from registered state.
  assign busy     = (state_q == S_CLEAR);
  assign clr_done = (state_q == S_DONE);

endmodule

// File: rtl/regfile_param.sv
// Parametrised register file: one write port, two combinational read ports,
// optional write-to-read bypass, write acknowledge and a sequential clear.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned NREGS  = NREGS_DEF,
  parameter int unsigned ADDR_W = $clog2(NREGS),
  parameter int unsigned BYPASS = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              w_en,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  output logic              w_ack,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_done
);

  logic [DATA_W-1:0] mem_q [NREGS];
  logic [DATA_W-1:0] mem_d [NREGS];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr_accept;
  logic              wr_in_range;
  logic              w_ack_q;

  regfile_clear_fsm #(
    .NREGS  (NREGS),
    .ADDR_W (ADDR_W)
  ) u_clear_fsm (
    .clk      (clk),
    .reset    (reset),
    .clr_req  (clr_req),
    .busy     (busy),
    .clr_done (clr_done),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // Not busy and not done means idle, where a clear request steals the
  // cycle; in done the request is ignored so the write still goes through.
  assign wr_accept   = w_en && !busy && !(clr_req && !clr_done);
  // Out-of-range writes are acknowledged but touch nothing.
  assign wr_in_range = (32'(w_addr) < NREGS);

  // Storage next-state: the clear engine owns the array while it runs.
  always_comb begin
    for (int i = 0; i < int'(NREGS); i++) begin
      mem_d[i] = mem_q[i];
    end
    if (clr_we) begin
      mem_d[clr_addr] = '0;
    end else if (wr_accept && wr_in_range) begin
      mem_d[w_addr] = w_data;
    end
  end

  // Storage array with asynchronous clear on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NREGS); i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Write acknowledge: one-cycle pulse after an accepted write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_ack_q <= 1'b0;
    end else begin
      w_ack_q <= wr_accept;
    end
  end

  assign w_ack = w_ack_q;

  // Read port A: unmapped indices read 0, optional forwarding of the
  // write being accepted this cycle.
  always_comb begin
    ra_data = '0;
    if (32'(ra_addr) < NREGS) begin
      if ((BYPASS != 0) && wr_accept && (ra_addr == w_addr)) begin
        ra_data = w_data;
      end else begin
        ra_data = mem_q[ra_addr];
      end
    end
  end

  // Read port B: same behaviour as port A.
  always_comb begin
    rb_data = '0;
    if (32'(rb_addr) < NREGS) begin
      if ((BYPASS != 0) && wr_accept && (rb_addr == w_addr)) begin
        rb_data = w_data;
      end else begin
        rb_data = mem_q[rb_addr];
      end
    end
  end

endmodule

// File: tb/tb_regfile_param.sv
// Directed bench for regfile_param: default bypass instance, a no-bypass
// instance sharing its inputs, and a 6 x 16 instance.
module tb_regfile_param;

  logic       clk = 1'b0;
  logic       reset;

  logic       w_en, clr_req;
  logic [1:0] w_addr, ra_addr, rb_addr;
  logic [7:0] w_data;

  logic [7:0] ra_a, rb_a, ra_n, rb_n;
  logic       ack_a, busy_a, done_a, ack_n, busy_n, done_n;

  logic        w_en6, clr6;
  logic [2:0]  w_addr6, ra6, rb6;
  logic [15:0] w_data6, ra_d6, rb_d6;
  logic        ack6, busy6, done6;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regfile_param #(.DATA_W(8), .NREGS(4), .BYPASS(1)) dut (
    .clk(clk), .reset(reset), .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
    .ra_addr(ra_addr), .rb_addr(rb_addr), .ra_data(ra_a), .rb_data(rb_a),
    .w_ack(ack_a), .clr_req(clr_req), .busy(busy_a), .clr_done(done_a)
  );

  regfile_param #(.DATA_W(8), .NREGS(4), .BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
    .ra_addr(ra_addr), .rb_addr(rb_addr), .ra_data(ra_n), .rb_data(rb_n),
    .w_ack(ack_n), .clr_req(clr_req), .busy(busy_n), .clr_done(done_n)
  );

  regfile_param #(.DATA_W(16), .NREGS(6), .BYPASS(1)) dut6 (
    .clk(clk), .reset(reset), .w_en(w_en6), .w_addr(w_addr6), .w_data(w_data6),
    .ra_addr(ra6), .rb_addr(rb6), .ra_data(ra_d6), .rb_data(rb_d6),
    .w_ack(ack6), .clr_req(clr6), .busy(busy6), .clr_done(done6)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] exp6;
    reset = 1'b1;
    w_en = 0; clr_req = 0; w_addr = 0; ra_addr = 0; rb_addr = 0; w_data = 0;
    w_en6 = 0; clr6 = 0; w_addr6 = 0; ra6 = 0; rb6 = 0; w_data6 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_ack", 32'(ack_a), 32'd0);
    chk("rst_ra", 32'(ra_a), 32'd0);
    chk("rst_busy6", 32'(busy6), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Basic write to r2 and w_ack timing
    w_en = 1; w_addr = 2; w_data = 8'h5A; ra_addr = 2; rb_addr = 0;
    #1;
    chk("ack_before", 32'(ack_a), 32'd0);
    tick();
    w_en = 0;
    #1;
    chk("ack_pulse", 32'(ack_a), 32'd1);
    chk("r2_ra", 32'(ra_a), 32'h5A);
    chk("r0_rb", 32'(rb_a), 32'h00);
    chk("r2_nb", 32'(ra_n), 32'h5A);
    tick();
    chk("ack_once", 32'(ack_a), 32'd0);

    // Bypass versus no bypass
    w_en = 1; w_addr = 1; w_data = 8'h11;
    tick();
    w_data = 8'hF0; ra_addr = 1;
    #1;
    chk("byp_on", 32'(ra_a), 32'hF0);
    chk("byp_off_pre", 32'(ra_n), 32'h11);
    tick();
    w_en = 0;
    #1;
    chk("byp_off_post", 32'(ra_n), 32'hF0);
    chk("byp_on_post", 32'(ra_a), 32'hF0);

    // Load r0..r3 then clear, with a write attempted while busy
    for (int i = 0; i < 4; i++) begin
      w_en = 1; w_addr = 2'(i); w_data = 8'(i + 1);
      tick();
    end
    w_en = 0; clr_req = 1;
    #1;
    chk("clr_idle_busy", 32'(busy_a), 32'd0);
    tick();
    clr_req = 0; w_en = 1; w_addr = 3; w_data = 8'h77; ra_addr = 0; rb_addr = 2;
    #1;
    chk("clr_c1_busy", 32'(busy_a), 32'd1);
    chk("clr_c1_ack", 32'(ack_a), 32'd0);
    chk("clr_c1_r0", 32'(ra_a), 32'h01);
    tick();
    chk("clr_c2_busy", 32'(busy_a), 32'd1);
    chk("clr_c2_ack", 32'(ack_a), 32'd0);
    chk("clr_c2_r0", 32'(ra_a), 32'h00);
    tick();
    ra_addr = 1;
    #1;
    chk("clr_c3_busy", 32'(busy_a), 32'd1);
    chk("clr_c3_ack", 32'(ack_a), 32'd0);
    chk("clr_c3_r1", 32'(ra_a), 32'h00);
    chk("clr_c3_r2", 32'(rb_a), 32'h03);
    tick();
    chk("clr_c4_busy", 32'(busy_a), 32'd1);
    chk("clr_c4_ack", 32'(ack_a), 32'd0);
    chk("clr_c4_r2", 32'(rb_a), 32'h00);
    tick();
    w_en = 0;
    #1;
    chk("done_busy", 32'(busy_a), 32'd0);
    chk("done_pulse", 32'(done_a), 32'd1);
    chk("done_ack", 32'(ack_a), 32'd0);
    tick();
    chk("done_once", 32'(done_a), 32'd0);
    chk("idle_busy", 32'(busy_a), 32'd0);
    chk("idle_ack", 32'(ack_a), 32'd0);
    for (int i = 0; i < 4; i++) begin
      ra_addr = 2'(i);
      #1;
      chk($sformatf("clr_end_r%0d", i), 32'(ra_a), 32'h00);
    end

    // Write together with clr_req is dropped; then async reset mid-clear
    w_en = 1; w_addr = 2; w_data = 8'h99;
    tick();
    w_en = 1; w_addr = 3; w_data = 8'h77; clr_req = 1;
    tick();
    w_en = 0; clr_req = 0;
    #1;
    chk("wclr_ack", 32'(ack_a), 32'd0);
    chk("wclr_busy", 32'(busy_a), 32'd1);
    tick();
    #2;
    reset = 1'b1;
    #1;
    chk("arst_busy", 32'(busy_a), 32'd0);
    ra_addr = 2;
    #1;
    chk("arst_r2", 32'(ra_a), 32'h00);
    ra_addr = 3;
    #1;
    chk("wclr_r3", 32'(ra_a), 32'h00);
    reset = 1'b0;
    w_en = 1; w_addr = 1; w_data = 8'h3C;
    tick();
    w_en = 0; ra_addr = 1;
    #1;
    chk("post_rst_ack", 32'(ack_a), 32'd1);
    chk("post_rst_r1", 32'(ra_a), 32'h3C);
    chk("post_rst_busy", 32'(busy_a), 32'd0);

    // 6 x 16 instance: in-range and out-of-range writes
    w_en6 = 1; w_addr6 = 0; w_data6 = 16'h1234;
    tick();
    w_addr6 = 5; w_data6 = 16'hBEEF;
    tick();
    w_en6 = 0; ra6 = 5;
    #1;
    chk("n6_ack", 32'(ack6), 32'd1);
    chk("n6_r5", 32'(ra_d6), 32'hBEEF);
    w_en6 = 1; w_addr6 = 7; w_data6 = 16'hDEAD;
    tick();
    w_en6 = 0; ra6 = 7; rb6 = 6;
    #1;
    chk("n6_oor_ack", 32'(ack6), 32'd1);
    chk("n6_oor_ra7", 32'(ra_d6), 32'h0);
    chk("n6_oor_rb6", 32'(rb_d6), 32'h0);
    for (int i = 0; i < 6; i++) begin
      ra6 = 3'(i);
      exp6 = (i == 0) ? 16'h1234 : (i == 5) ? 16'hBEEF : 16'h0000;
      #1;
      chk($sformatf("n6_keep_r%0d", i), 32'(ra_d6), 32'(exp6));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
